// File: rtl/i2s_tx_pkg.sv
// Shared audio definitions for the I2S transmitter: sample size codes, frame
// geometry and helpers that turn a size code into an MSB-aligned slot word.
package i2s_tx_pkg;

  localparam logic [3:0] S_8BIT  = 4'd0;
  localparam logic [3:0] S_12BIT = 4'd1;
  localparam logic [3:0] S_16BIT = 4'd3;
  localparam logic [3:0] S_24BIT = 4'd4;
  localparam logic [3:0] S_32BIT = 4'd5;

  localparam int unsigned SAMPLE_W = 32;

  // Frame positions: 64 BCLKs per frame, left slot at 0, right slot at 32.
  localparam logic [5:0] LEFT_LOAD_BIT  = 6'd0;
  localparam logic [5:0] RIGHT_LOAD_BIT = 6'd32;
  localparam logic [5:0] LR_RISE_BIT    = 6'd31;
  localparam logic [5:0] LAST_BIT       = 6'd63;

  // Unlisted codes fall back to 16-bit samples.
  function automatic logic [5:0] size_to_width(input logic [3:0] code);
    case (code)
      S_8BIT:  return 6'd8;
      S_12BIT: return 6'd12;
      S_16BIT: return 6'd16;
      S_24BIT: return 6'd24;
      S_32BIT: return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

  function automatic logic [SAMPLE_W-1:0] msb_align(input logic [SAMPLE_W-1:0] sample,
                                                    input logic [3:0]          code);
    logic [5:0] width;
    width = size_to_width(code);
    return sample << (6'd32 - width);
  endfunction

endpackage

// File: rtl/i2s_tx_sample_fifo.sv
// Synchronous sample FIFO between the assembly stage and the I2S serialiser.
// Push when full and pop when empty are ignored; push and pop may coincide.
module i2s_tx_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: divides clk down to BCLK, frames 64 BCLKs per LRCLK
// period and shifts FIFO samples out MSB first, keeping L/R alignment on underrun.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] sample_in,
  input  logic [3:0]  sample_size,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        underrun
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                underrun_q, underrun_d;
  logic                skip_frame_q, skip_frame_d;
  logic                drop_next_q, drop_next_d;

  logic                div_wrap, fall_tick;
  logic                slot_avail, slot_pop, drop_now;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_rd_data;

  assign fifo_push = sample_valid && !fifo_full;
  assign fifo_pop  = slot_pop || drop_now;

  i2s_tx_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (sample_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    div_wrap  = (div_cnt_q == DW'(CLK_DIV - 1));
    fall_tick = enable && div_wrap && bclk_q;
    // A pending drop owns the FIFO head, so a slot never sees the late right sample.
    slot_avail = !fifo_empty && !drop_next_q;
    drop_now   = drop_next_q && !fifo_empty;

    div_cnt_d    = div_cnt_q;
    bclk_d       = bclk_q;
    lrclk_d      = lrclk_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    underrun_d   = 1'b0;
    skip_frame_d = skip_frame_q;
    drop_next_d  = drop_next_q;
    slot_pop     = 1'b0;

    if (drop_now) drop_next_d = 1'b0;

    if (!enable) begin
      div_cnt_d    = '0;
      bclk_d       = 1'b0;
      lrclk_d      = 1'b0;
      bit_cnt_d    = LAST_BIT;
      shift_d      = '0;
      skip_frame_d = 1'b0;
    end else begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
      if (div_wrap) bclk_d = !bclk_q;

      if (fall_tick) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        lrclk_d   = (bit_cnt_d >= LR_RISE_BIT) && (bit_cnt_d != LAST_BIT);
        shift_d   = {shift_q[SAMPLE_W-2:0], 1'b0};

        if (bit_cnt_d == LEFT_LOAD_BIT) begin
          // An empty left slot silences the whole frame so the right slot stays right.
          skip_frame_d = !slot_avail;
          if (slot_avail) begin
            shift_d  = msb_align(fifo_rd_data, sample_size);
            slot_pop = 1'b1;
          end else begin
            shift_d    = '0;
            underrun_d = 1'b1;
          end
        end else if (bit_cnt_d == RIGHT_LOAD_BIT) begin
          if (skip_frame_q) begin
            shift_d      = '0;
            skip_frame_d = 1'b0;
          end else if (slot_avail) begin
            shift_d  = msb_align(fifo_rd_data, sample_size);
            slot_pop = 1'b1;
          end else begin
            shift_d     = '0;
            underrun_d  = 1'b1;
            drop_next_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      bit_cnt_q    <= LAST_BIT;
      shift_q      <= '0;
      underrun_q   <= 1'b0;
      skip_frame_q <= 1'b0;
      drop_next_q  <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      underrun_q   <= underrun_d;
      skip_frame_q <= skip_frame_d;
      drop_next_q  <= drop_next_d;
    end
  end

  assign sample_ready = !fifo_full;
  assign i2s_bclk     = bclk_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = shift_q[SAMPLE_W-1];
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a frame-level reference model built from
// queues and arithmetic, a simple I2S receiver, directed and random stimulus.
module tb_i2s_tx;

  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] sample_in = '0;
  logic [3:0]  sample_size = 4'd3;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, underrun;

  i2s_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_size  (sample_size),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .underrun     (underrun)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  int          mdl_cycles = 0;
  int          mdl_bit = 63;
  logic [31:0] mdl_word = '0;
  bit          mdl_skip = 0;
  bit          mdl_drop = 0;
  bit          mdl_tick = 0;
  logic        exp_ready = 1'b1;
  logic        exp_bclk = 1'b0;
  logic        exp_lrclk = 1'b0;
  logic        exp_sdata = 1'b0;
  logic        exp_underrun = 1'b0;

  logic [31:0] rx_acc = '0;
  logic [31:0] rx_left = '0;
  logic [31:0] rx_right = '0;
  logic        rx_lr_prev = 1'b0;
  logic        rx_bclk_prev = 1'b0;
  int          ur_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tb_width(input logic [3:0] code);
    case (code)
      4'd0:    return 8;
      4'd1:    return 12;
      4'd4:    return 24;
      4'd5:    return 32;
      default: return 16;
    endcase
  endfunction

  // Reference model: FIFO as a queue, frame position from elapsed enabled clocks.
  always @(posedge clk) begin : ref_model
    int          pre_size;
    int          w;
    bit          push_ok, avail, take, drop_now, drop_set;
    logic [31:0] head;
    pre_size     = exp_q.size();
    push_ok      = sample_valid && (pre_size < FIFO_DEPTH);
    take         = 0;
    drop_set     = 0;
    drop_now     = 0;
    mdl_tick     = 0;
    exp_underrun = 1'b0;
    if (rst) begin
      exp_q.delete();
      mdl_cycles = 0;
      mdl_bit    = 63;
      mdl_word   = '0;
      mdl_skip   = 0;
      mdl_drop   = 0;
    end else begin
      drop_now = mdl_drop && (pre_size > 0);
      avail    = (pre_size > 0) && !mdl_drop;
      if (!enable) begin
        mdl_cycles = 0;
        mdl_bit    = 63;
        mdl_word   = '0;
        mdl_skip   = 0;
      end else begin
        mdl_cycles++;
        if (mdl_cycles % (2 * CLK_DIV) == 0) begin
          mdl_tick = 1;
          mdl_bit  = (mdl_bit + 1) % 64;
          if (mdl_bit == 0 || mdl_bit == 32) begin
            if (mdl_bit == 32 && mdl_skip) begin
              mdl_word = '0;
              mdl_skip = 0;
            end else if (avail) begin
              head     = exp_q[0];
              w        = tb_width(sample_size);
              mdl_word = head << (32 - w);
              take     = 1;
              if (mdl_bit == 0) mdl_skip = 0;
            end else begin
              mdl_word     = '0;
              exp_underrun = 1'b1;
              if (mdl_bit == 0) mdl_skip = 1;
              else drop_set = 1;
            end
          end
        end
      end
      if (drop_now || take) void'(exp_q.pop_front());
      if (drop_now) mdl_drop = 0;
      if (drop_set) mdl_drop = 1;
      if (push_ok) exp_q.push_back(sample_in);
    end
    exp_ready = (exp_q.size() < FIFO_DEPTH);
    exp_bclk  = ((mdl_cycles / CLK_DIV) % 2 == 1);
    exp_lrclk = (mdl_bit >= 31 && mdl_bit <= 62);
    exp_sdata = mdl_word[31 - (mdl_bit % 32)];
  end

  // Per-cycle comparison and an I2S receiver sampling on BCLK rising edges.
  always @(posedge clk) begin
    #1;
    check_eq("ready", {31'b0, sample_ready}, {31'b0, exp_ready});
    check_eq("bclk", {31'b0, i2s_bclk}, {31'b0, exp_bclk});
    check_eq("lrclk", {31'b0, i2s_lrclk}, {31'b0, exp_lrclk});
    check_eq("sdata", {31'b0, i2s_sdata}, {31'b0, exp_sdata});
    check_eq("underrun", {31'b0, underrun}, {31'b0, exp_underrun});
    if (underrun === 1'b1) ur_total++;
    if (rst || !enable) begin
      rx_acc       = '0;
      rx_lr_prev   = 1'b0;
      rx_bclk_prev = 1'b0;
    end else begin
      if (i2s_bclk && !rx_bclk_prev) begin
        rx_acc = {rx_acc[30:0], i2s_sdata};
        if (i2s_lrclk != rx_lr_prev) begin
          if (!rx_lr_prev) rx_left = rx_acc;
          else rx_right = rx_acc;
          rx_acc = '0;
        end
        rx_lr_prev = i2s_lrclk;
      end
      rx_bclk_prev = i2s_bclk;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_word(input logic [31:0] d);
    sample_in    = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_bit(input int n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(mdl_tick && mdl_bit == n) && k < 2000);
    check_eq("wait_bit_budget", {31'b0, (k < 2000)}, 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] l_word, r_word, mask;
    int          base;
    int          w;

    // Reset held for three clocks.
    repeat (3) @(negedge clk);
    check_eq("rst_bclk", {31'b0, i2s_bclk}, 32'd0);
    check_eq("rst_lrclk", {31'b0, i2s_lrclk}, 32'd0);
    check_eq("rst_sdata", {31'b0, i2s_sdata}, 32'd0);
    check_eq("rst_ready", {31'b0, sample_ready}, 32'd1);
    check_eq("rst_underrun", {31'b0, underrun}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 16-bit pair loaded before the stream starts.
    sample_size = 4'd3;
    drive_word(32'h0000A5A5);
    drive_word(32'h00001234);
    enable = 1'b1;
    wait_bit(34);
    check_eq("t2_left", rx_left, 32'hA5A50000);

    // 24-bit left then 8-bit right; size is applied at slot-load time.
    wait_bit(40);
    sample_size = 4'd4;
    drive_word(32'h00ABCDEF);
    drive_word(32'h0000005A);
    wait_bit(1);
    check_eq("t2_right", rx_right, 32'h12340000);
    wait_bit(10);
    sample_size = 4'd0;
    wait_bit(34);
    check_eq("t3_left", rx_left, 32'hABCDEF00);
    wait_bit(1);
    check_eq("t3_right", rx_right, 32'h5A000000);

    // Empty FIFO: one underrun per frame, then a pair lands on the right channels.
    wait_bit(40);
    base = ur_total;
    wait_bit(40);
    wait_bit(40);
    check_eq("t4_underruns", ur_total - base, 32'd2);
    sample_size = 4'd3;
    l_word = $urandom_range(0, 16'hFFFF);
    r_word = $urandom_range(0, 16'hFFFF);
    drive_word(l_word);
    drive_word(r_word);
    wait_bit(34);
    check_eq("t4_left", rx_left, l_word << 16);
    wait_bit(1);
    check_eq("t4_right", rx_right, r_word << 16);

    // Late right sample is dropped; the following pair stays aligned.
    sample_size = 4'd0;
    wait_bit(40);
    base = ur_total;
    drive_word(32'h00000077);
    wait_bit(34);
    check_eq("t5_left", rx_left, 32'h77000000);
    check_eq("t5_right_underrun", ur_total - base, 32'd1);
    drive_word(32'h00000099);
    wait_bit(40);
    check_eq("t5_dropped", {29'b0, 3'(exp_q.size())}, 32'd0);
    drive_word(32'h00000011);
    drive_word(32'h00000022);
    wait_bit(34);
    check_eq("t5_left2", rx_left, 32'h11000000);
    wait_bit(1);
    check_eq("t5_right2", rx_right, 32'h22000000);

    // Fill while idle, overflow attempt, then reset mid-frame.
    enable = 1'b0;
    sample_size = 4'd3;
    @(negedge clk);
    for (int i = 0; i < 5; i++) drive_word(32'h00001000 + 32'(i));
    check_eq("t6_full_ready", {31'b0, sample_ready}, 32'd0);
    enable = 1'b1;
    wait_bit(34);
    check_eq("t6_left", rx_left, 32'h10000000);
    wait_bit(45);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_bclk", {31'b0, i2s_bclk}, 32'd0);
    check_eq("t6_rst_lrclk", {31'b0, i2s_lrclk}, 32'd0);
    check_eq("t6_rst_sdata", {31'b0, i2s_sdata}, 32'd0);
    check_eq("t6_rst_ready", {31'b0, sample_ready}, 32'd1);
    rst = 1'b0;

    // Random traffic: fast phase overflows, slow phase underruns, one pause.
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) sample_size = 4'($urandom_range(0, 15));
      if (c == 2100) enable = 1'b0;
      if (c == 2180) enable = 1'b1;
      if (c == 4700) pulse_reset();
      w    = tb_width(sample_size);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      if ($urandom_range(0, (c < 3000) ? 59 : 199) == 0) begin
        sample_in    = $urandom & mask;
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
